// File: rtl/aud_recorder.sv
// aud_recorder: captures left-channel I2S samples from the ADC into consecutive SRAM words.
// The optional sticky clip flag is enabled by defining AUD_REC_CLIP_DETECT_EN.
module aud_recorder #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 20,
    parameter int unsigned ADDR_MAX = 2**20 - 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic [ADDR_W:0]   o_rec_len,
`ifdef AUD_REC_CLIP_DETECT_EN
    output logic              o_clip,
`endif
    output logic              o_finished
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(ADDR_MAX) + (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] POS_FULL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LRC,
        SHIFT,
        STORE,
        PAUSE
    } state_t;

    state_t             state_q, state_d;
    logic               lrc_prev_q;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               we_q, we_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               fin_q, fin_d;
    logic               pend_q, pend_d;
`ifdef AUD_REC_CLIP_DETECT_EN
    logic               clip_q, clip_d;
`endif

    // Start of a left slot: LRCK falls from right to left.
    logic fall;
    assign fall = lrc_prev_q & ~i_lrc;

    // Next-state and datapath updates for the capture FSM.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        len_d    = len_q;
        fin_d    = 1'b0;
        pend_d   = pend_q;
`ifdef AUD_REC_CLIP_DETECT_EN
        clip_d   = clip_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = WAIT_LRC;
                    ptr_d   = '0;
                    addr_d  = '0;
                    len_d   = '0;
                    pend_d  = 1'b0;
`ifdef AUD_REC_CLIP_DETECT_EN
                    clip_d  = 1'b0;
`endif
                end
            end
            WAIT_LRC: begin
                if (i_stop) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else if (pend_q) begin
                    state_d = PAUSE;
                    pend_d  = 1'b0;
                end else begin
                    if (i_pause) pend_d = 1'b1;
                    if (fall) begin
                        state_d  = SHIFT;
                        bitcnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                if (i_stop) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else begin
                    if (i_pause) pend_d = 1'b1;
                    shift_d  = {shift_q[DATA_W-2:0], i_data};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = STORE;
                        we_d    = 1'b1;
                        data_d  = {shift_q[DATA_W-2:0], i_data};
                        addr_d  = ptr_q;
                    end
                end
            end
            STORE: begin
                if (len_q != LEN_MAX) len_d = len_q + (ADDR_W+1)'(1);
`ifdef AUD_REC_CLIP_DETECT_EN
                if (data_q == POS_FULL || data_q == NEG_FULL) clip_d = 1'b1;
`endif
                if (ptr_q == A_MAX || i_stop) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (pend_q) begin
                        state_d = PAUSE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = WAIT_LRC;
                    end
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else if (i_pause) begin
                    state_d = WAIT_LRC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            lrc_prev_q <= 1'b1;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            len_q      <= '0;
            fin_q      <= 1'b0;
            pend_q     <= 1'b0;
`ifdef AUD_REC_CLIP_DETECT_EN
            clip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lrc_prev_q <= i_lrc;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            len_q      <= len_d;
            fin_q      <= fin_d;
            pend_q     <= pend_d;
`ifdef AUD_REC_CLIP_DETECT_EN
            clip_q     <= clip_d;
`endif
        end
    end

    assign o_address  = addr_q;
    assign o_data     = data_q;
    assign o_we       = we_q;
    assign o_rec_len  = len_q;
    assign o_finished = fin_q;
`ifdef AUD_REC_CLIP_DETECT_EN
    assign o_clip     = clip_q;
`endif

endmodule
